shift_add_multiplier: RTL
=========================

Name: shift_add_multiplier

Overview:
- Sequential unsigned add-and-shift multiplier. It is the DUT the grader's transaction monitor samples through multiplier_itf.
- Accepts a multiplicand/multiplier pair on a start pulse and iterates one ADD and one SHIFT step per multiplier bit.
- Presents a 2*WIDTH-bit product with done/ready status.
- Exposes its current operation state (mult_op) so monitors and debug prints can report it.

Parameters:
- WIDTH, 8, operand width in bits; product is 2*WIDTH bits; legal range 2..32.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset_n  input  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- start  input  1  request to begin a multiply; sampled on rising clk edge.
- multiplicand  input  WIDTH  operand A; captured on accepted start.
- multiplier  input  WIDTH  operand B; captured on accepted start.
- ready  output  1  high when a start will be accepted (state NONE or DONE).
- done  output  1  high while state is DONE; product valid.
- product  output  2*WIDTH  result; valid while done=1.
- mult_op  output  2  current operation: NONE=0, ADD=1, SHIFT=2, DONE=3.

Behaviour:
- Reset (reset_n=0, any time, asynchronous):
  - mult_op=NONE, ready=1, done=0, product=0, iteration counter=0.
  - Reset wins over start in the same cycle.
  - Reset mid-operation abandons the operation; no partial product is retained.
- Datapath registers:
  - Accumulator of 2*WIDTH+1 bits: the upper WIDTH+1 bits hold the partial sum including the carry; the lower WIDTH bits hold the multiplier being consumed.
  - Captured multiplicand, WIDTH bits.
  - Iteration counter, clog2(WIDTH+1) bits.
- start accepted at edge k (ready=1, start=1):
  - Multiplicand register <= multiplicand.
  - Accumulator <= {0, multiplier}.
  - Counter <= 0; mult_op <= ADD; done <= 0; ready <= 0.
- ADD state (one cycle):
  - If accumulator LSB=1, upper WIDTH+1 bits <= upper WIDTH bits + multiplicand (carry kept in the top bit); else unchanged.
  - mult_op <= SHIFT.
- SHIFT state (one cycle):
  - Accumulator <= accumulator >> 1, logical, zero fill; counter <= counter+1.
  - If counter was WIDTH-1: mult_op <= DONE, product <= low 2*WIDTH bits of the shifted accumulator, done <= 1, ready <= 1.
  - Else mult_op <= ADD.
- Latency:
  - Iteration i completes at edge k+2i; DONE is entered at edge k+2*WIDTH.
  - done is visible 2*WIDTH cycles after the accepting edge (16 cycles for WIDTH=8).
  - Latency is data-independent: no early termination on zero operands.
- DONE state:
  - product and done hold indefinitely until the next accepted start or reset.
  - start in DONE is accepted exactly as from NONE: done drops on the same accepting edge, and product holds its old value until the new result is written.
- start while mult_op is ADD or SHIFT is ignored: no restart, and no change to the in-flight operands.
- Operands change while busy: no effect; only values captured at acceptance are used.
- Arithmetic:
  - Unsigned only; product = multiplicand*multiplier exactly.
  - No overflow is possible: max (2^WIDTH-1)^2 < 2^(2*WIDTH).
- mult_op always reflects the registered state; ready and done are decoded from mult_op only (no combinational path from start).
- mult_op never holds an encoding outside 0..3; unreachable states return to NONE.

Test Plan:
- Reset, then start with 0xFF*0xFF (WIDTH=8) -> mult_op alternates ADD/SHIFT for 16 cycles; done=1 on the 16th edge after acceptance; product=0xFE01; ready=1.
- Start 0x00*0xA5, then 0xA5*0x00 -> each done after exactly 16 cycles, product=0x0000, no early finish.
- Start 0x0C*0x0A, pulse start with 0x03*0x03 at cycle 5 -> second start ignored; product=0x0078; next start after done yields 0x0009.
- Start 0x7F*0x81, assert reset_n=0 asynchronously mid-cycle at cycle 7 -> outputs immediately mult_op=NONE, ready=1, done=0, product=0; a fresh start 0x02*0x03 then gives 0x0006.
- Back-to-back: start 0x10*0x10, then start 0x01*0xFF held on the same edge done rises to ready -> done drops next edge, product stays 0x0100 until new done with 0x00FF.
- Start and reset_n=0 in the same cycle -> reset wins; mult_op=NONE, no operation begins.

Source files
------------

// File: rtl/shift_add_multiplier.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : shift_add_multiplier
//  Description : Sequential unsigned add-and-shift multiplier. One ADD cycle
//                and one SHIFT cycle per multiplier bit, giving a fixed
//                2*WIDTH-cycle latency from the accepting edge to done.
//  Revision    : 1.0 - initial release
// ============================================================================
module shift_add_multiplier #(
   parameter int WIDTH = 8
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               start,
   input  logic [WIDTH-1:0]   multiplicand,
   input  logic [WIDTH-1:0]   multiplier,
   output logic               ready,
   output logic               done,
   output logic [2*WIDTH-1:0] product,
   output logic [1:0]         mult_op
);

   // Counter must be able to hold WIDTH (one past the last iteration index).
   localparam int               CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   typedef enum logic [1:0] {
      OP_NONE  = 2'd0,
      OP_ADD   = 2'd1,
      OP_SHIFT = 2'd2,
      OP_DONE  = 2'd3
   } op_e;

   op_e                state_q;
   // Upper WIDTH+1 bits: partial sum with carry. Lower WIDTH bits: multiplier
   // bits still to be consumed (LSB is the bit for the current iteration).
   logic [2*WIDTH:0]   acc_q;
   logic [WIDTH-1:0]   mcand_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [2*WIDTH-1:0] product_q;

   logic [WIDTH:0]     sum_d;
   logic [2*WIDTH:0]   shifted_d;
   logic               last_iter_d;

   // Partial-sum adder: the carry-out lands in the top accumulator bit.
   // The top bit is always zero here because every SHIFT clears it.
   assign sum_d       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mcand_q};
   assign shifted_d   = {1'b0, acc_q[2*WIDTH:1]};
   assign last_iter_d = (cnt_q == LAST_CNT);

   // Operation sequencer and datapath: capture, add, shift, publish result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= OP_NONE;
         acc_q     <= '0;
         mcand_q   <= '0;
         cnt_q     <= '0;
         product_q <= '0;
      end else begin
         case (state_q)
            OP_NONE, OP_DONE: begin
               // Product is left untouched so the previous result stays
               // visible until the new one is written.
               if (start) begin
                  mcand_q <= multiplicand;
                  acc_q   <= {{(WIDTH+1){1'b0}}, multiplier};
                  cnt_q   <= '0;
                  state_q <= OP_ADD;
               end
            end
            OP_ADD: begin
               if (acc_q[0]) begin
                  acc_q[2*WIDTH:WIDTH] <= sum_d;
               end
               state_q <= OP_SHIFT;
            end
            OP_SHIFT: begin
               acc_q <= shifted_d;
               cnt_q <= cnt_q + 1'b1;
               if (last_iter_d) begin
                  product_q <= shifted_d[2*WIDTH-1:0];
                  state_q   <= OP_DONE;
               end else begin
                  state_q   <= OP_ADD;
               end
            end
            default: begin
               state_q <= OP_NONE;
            end
         endcase
      end
   end

   // Status is a pure decode of the registered state; start never reaches it.
   assign ready   = (state_q == OP_NONE) || (state_q == OP_DONE);
   assign done    = (state_q == OP_DONE);
   assign mult_op = state_q;
   assign product = product_q;

endmodule
`default_nettype wire
